// File: rtl/jk_drv_pkg.sv
// Shared types and excitation codes for the JK bank driver.
package jk_drv_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        CHECK = 2'd2,
        DONE  = 2'd3
    } state_e;

    // Excitation codes, packed as {j, k}
    localparam logic [1:0] JK_HOLD = 2'b00;
    localparam logic [1:0] JK_RST  = 2'b01;
    localparam logic [1:0] JK_SET  = 2'b10;
    localparam logic [1:0] JK_TGL  = 2'b11;

endpackage

// File: rtl/jk_excitation.sv
// Per-bit JK excitation: picks J/K that move q to t on the next edge.
module jk_excitation
    import jk_drv_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic [WIDTH-1:0] q,
    input  logic [WIDTH-1:0] t,
    input  logic             toggle,
    output logic [WIDTH-1:0] j,
    output logic [WIDTH-1:0] k
);

    logic [1:0] jk;

    // Unchanged bits hold; changing bits set/reset, or toggle when the policy asks for it
    always_comb begin
        j  = '0;
        k  = '0;
        jk = JK_HOLD;
        for (int i = 0; i < int'(WIDTH); i++) begin
            jk = JK_HOLD;
            if (q[i] != t[i]) begin
                if (toggle) begin
                    jk = JK_TGL;
                end else if (t[i]) begin
                    jk = JK_SET;
                end else begin
                    jk = JK_RST;
                end
            end
            j[i] = jk[1];
            k[i] = jk[0];
        end
    end

endmodule

// File: rtl/jk_excitation_driver.sv
// Drives a JK register bank to a requested word, verifies it and retries on mismatch.
module jk_excitation_driver
    import jk_drv_pkg::*;
#(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned MAX_RETRY = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             tgt_valid,
    output logic             tgt_ready,
    input  logic [WIDTH-1:0] tgt_data,
    input  logic             tgt_toggle,
    input  logic [WIDTH-1:0] q_fb,
    output logic [WIDTH-1:0] j,
    output logic [WIDTH-1:0] k,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [WIDTH-1:0] mismatch
);

    // Keep the counter at least one bit wide so MAX_RETRY=0 still elaborates
    localparam int unsigned CNT_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   tgt_q, tgt_d;
    logic               toggle_q, toggle_d;
    logic [CNT_W-1:0]   retry_q, retry_d;
    logic               err_q, err_d;
    logic [WIDTH-1:0]   mismatch_q, mismatch_d;
    logic [WIDTH-1:0]   exc_j, exc_k;

    jk_excitation #(.WIDTH(WIDTH)) u_exc (
        .q      (q_fb),
        .t      (tgt_q),
        .toggle (toggle_q),
        .j      (exc_j),
        .k      (exc_k)
    );

    // State and command registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            tgt_q      <= '0;
            toggle_q   <= 1'b0;
            retry_q    <= '0;
            err_q      <= 1'b0;
            mismatch_q <= '0;
        end else begin
            state_q    <= state_d;
            tgt_q      <= tgt_d;
            toggle_q   <= toggle_d;
            retry_q    <= retry_d;
            err_q      <= err_d;
            mismatch_q <= mismatch_d;
        end
    end

    // Next-state and bank drive; J/K only leave zero during DRIVE so the bank holds otherwise
    always_comb begin
        state_d    = state_q;
        tgt_d      = tgt_q;
        toggle_d   = toggle_q;
        retry_d    = retry_q;
        err_d      = err_q;
        mismatch_d = mismatch_q;
        j          = '0;
        k          = '0;
        unique case (state_q)
            IDLE: begin
                if (tgt_valid) begin
                    tgt_d    = tgt_data;
                    toggle_d = tgt_toggle;
                    retry_d  = '0;
                    state_d  = DRIVE;
                end
            end
            DRIVE: begin
                j       = exc_j;
                k       = exc_k;
                state_d = CHECK;
            end
            CHECK: begin
                if (q_fb == tgt_q) begin
                    err_d      = 1'b0;
                    mismatch_d = q_fb ^ tgt_q;
                    state_d    = DONE;
                end else if (retry_q < CNT_W'(MAX_RETRY)) begin
                    retry_d = retry_q + CNT_W'(1);
                    state_d = DRIVE;
                end else begin
                    err_d      = 1'b1;
                    mismatch_d = q_fb ^ tgt_q;
                    state_d    = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign tgt_ready = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign done      = (state_q == DONE);
    assign err       = err_q;
    assign mismatch  = mismatch_q;

endmodule

// File: tb/tb_jk_excitation_driver.sv
// Directed bench for jk_excitation_driver with a behavioural JK bank on the same clock.
module tb_jk_excitation_driver;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       tgt_valid = 1'b0;
    logic       tgt_ready;
    logic [7:0] tgt_data = 8'h00;
    logic       tgt_toggle = 1'b0;
    logic [7:0] q_fb;
    logic [7:0] j, k;
    logic       busy, done, err;
    logic [7:0] mismatch;

    logic [7:0] bank_q = 8'h00;
    logic [7:0] stuck0 = 8'h00;
    logic       load_en = 1'b0;
    logic [7:0] load_val = 8'h00;

    int checks = 0;
    int errors = 0;

    jk_excitation_driver #(.WIDTH(8), .MAX_RETRY(3)) dut (
        .clk        (clk),
        .reset      (reset),
        .tgt_valid  (tgt_valid),
        .tgt_ready  (tgt_ready),
        .tgt_data   (tgt_data),
        .tgt_toggle (tgt_toggle),
        .q_fb       (q_fb),
        .j          (j),
        .k          (k),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .mismatch   (mismatch)
    );

    always #5 clk = ~clk;

    // JK bank: Q+ = J&~Q | ~K&Q, with optional stuck-at-0 bits on the output
    assign q_fb = bank_q & ~stuck0;
    always @(posedge clk) begin
        if (load_en) bank_q <= load_val;
        else         bank_q <= (j & ~q_fb) | (~k & q_fb);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load_bank(input logic [7:0] v);
        load_val = v;
        load_en  = 1'b1;
        step();
        load_en  = 1'b0;
    endtask

    task automatic test_reset();
        #1;
        checks++; if (tgt_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b exp 1", tgt_ready); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
        checks++; if ({j, k} !== 16'h0000) begin errors++; $display("FAIL reset_jk got %h exp 0000", {j, k}); end
        checks++; if ({done, err, mismatch} !== 10'h000) begin errors++; $display("FAIL reset_status got %h exp 000", {done, err, mismatch}); end
        step();
        step();
        reset = 1'b1;
        step();
    endtask

    // Runs one command from IDLE and checks J/K in DRIVE, the hold in CHECK and status in DONE
    task automatic run_simple(input string name, input logic [7:0] q0, input logic [7:0] tgt,
                              input logic tgl, input logic [7:0] exp_j, input logic [7:0] exp_k);
        load_bank(q0);
        tgt_data   = tgt;
        tgt_toggle = tgl;
        tgt_valid  = 1'b1;
        step();                                  // cycle 1: DRIVE
        tgt_valid = 1'b0;
        checks++; if ({j, k} !== {exp_j, exp_k}) begin errors++; $display("FAIL %s drive_jk got %h exp %h", name, {j, k}, {exp_j, exp_k}); end
        checks++; if ({tgt_ready, busy} !== 2'b01) begin errors++; $display("FAIL %s drive_ready_busy got %b exp 01", name, {tgt_ready, busy}); end
        step();                                  // cycle 2: CHECK
        checks++; if ({j, k} !== 16'h0000) begin errors++; $display("FAIL %s check_jk got %h exp 0000", name, {j, k}); end
        checks++; if (q_fb !== tgt) begin errors++; $display("FAIL %s bank_q got %h exp %h", name, q_fb, tgt); end
        step();                                  // cycle 3: DONE
        checks++; if ({done, err, mismatch} !== 10'h200) begin errors++; $display("FAIL %s done_err_mm got %h exp 200", name, {done, err, mismatch}); end
        step();                                  // cycle 4: IDLE
        checks++; if ({tgt_ready, done, busy} !== 3'b100) begin errors++; $display("FAIL %s idle_after got %b exp 100", name, {tgt_ready, done, busy}); end
    endtask

    task automatic test_set_reset();
        run_simple("set_reset", 8'h00, 8'hA5, 1'b0, 8'hA5, 8'h00);
    endtask

    task automatic test_toggle();
        run_simple("toggle", 8'hF0, 8'h0F, 1'b1, 8'hFF, 8'hFF);
    endtask

    task automatic test_no_change();
        run_simple("no_change", 8'h3C, 8'h3C, 1'b0, 8'h00, 8'h00);
    endtask

    task automatic test_retry_exhaust();
        int drives   = 0;
        int done_cyc = 0;
        load_bank(8'h00);
        stuck0     = 8'h04;
        tgt_data   = 8'h04;
        tgt_toggle = 1'b0;
        tgt_valid  = 1'b1;
        for (int c = 1; c <= 15; c++) begin
            step();
            tgt_valid = 1'b0;
            if (j == 8'h04 && k == 8'h00) drives++;
            if (done && done_cyc == 0) begin
                done_cyc = c;
                checks++; if ({err, mismatch} !== 9'h104) begin errors++; $display("FAIL retry_err_mm got %h exp 104", {err, mismatch}); end
            end
        end
        checks++; if (drives !== 4) begin errors++; $display("FAIL retry_drive_count got %0d exp 4", drives); end
        checks++; if (done_cyc !== 9) begin errors++; $display("FAIL retry_done_cycle got %0d exp 9", done_cyc); end
        stuck0 = 8'h00;
    endtask

    task automatic test_reset_mid_op();
        int done_seen = 0;
        load_bank(8'h00);
        tgt_data   = 8'hFF;
        tgt_toggle = 1'b0;
        tgt_valid  = 1'b1;
        step();                                  // DRIVE
        tgt_valid = 1'b0;
        step();                                  // CHECK
        reset = 1'b0;
        #1;
        checks++; if ({j, k} !== 16'h0000) begin errors++; $display("FAIL midreset_jk got %h exp 0000", {j, k}); end
        checks++; if ({busy, tgt_ready, done} !== 3'b010) begin errors++; $display("FAIL midreset_busy_ready_done got %b exp 010", {busy, tgt_ready, done}); end
        checks++; if ({err, mismatch} !== 9'h000) begin errors++; $display("FAIL midreset_err_mm got %h exp 000", {err, mismatch}); end
        for (int c = 0; c < 4; c++) begin
            step();
            if (done) done_seen++;
            if (c == 1) reset = 1'b1;
        end
        checks++; if (done_seen !== 0) begin errors++; $display("FAIL midreset_no_done got %0d exp 0", done_seen); end
        run_simple("after_reset", 8'h00, 8'h5A, 1'b0, 8'h5A, 8'h00);
    endtask

    task automatic test_back_to_back();
        logic [2:0] ready_hist = 3'b000;
        load_bank(8'h00);
        tgt_data   = 8'h22;
        tgt_toggle = 1'b0;
        tgt_valid  = 1'b1;
        step();                                  // cycle 1: DRIVE of 0x22
        tgt_data = 8'h11;
        checks++; if ({j, k} !== 16'h2200) begin errors++; $display("FAIL b2b_first_jk got %h exp 2200", {j, k}); end
        ready_hist[0] = tgt_ready;
        step();                                  // cycle 2
        ready_hist[1] = tgt_ready;
        step();                                  // cycle 3: DONE
        ready_hist[2] = tgt_ready;
        checks++; if ({done, err} !== 2'b10) begin errors++; $display("FAIL b2b_first_done got %b exp 10", {done, err}); end
        checks++; if (ready_hist !== 3'b000) begin errors++; $display("FAIL b2b_ready_busy got %b exp 000", ready_hist); end
        step();                                  // cycle 4: IDLE, accepts 0x11
        checks++; if (tgt_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready_c4 got %b exp 1", tgt_ready); end
        step();                                  // cycle 5: DRIVE of 0x11 from Q=0x22
        tgt_valid = 1'b0;
        checks++; if ({j, k} !== 16'h1122) begin errors++; $display("FAIL b2b_second_jk got %h exp 1122", {j, k}); end
        step();                                  // cycle 6: CHECK
        step();                                  // cycle 7: DONE
        checks++; if ({done, err, mismatch} !== 10'h200) begin errors++; $display("FAIL b2b_second_done got %h exp 200", {done, err, mismatch}); end
        checks++; if (q_fb !== 8'h11) begin errors++; $display("FAIL b2b_bank_q got %h exp 11", q_fb); end
        step();
    endtask

    initial begin
        test_reset();
        test_set_reset();
        test_toggle();
        test_no_change();
        test_retry_exhaust();
        test_reset_mid_op();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
